r2mdc_stage_ctrl: RTL and testbench
===================================

// Module: r2mdc_stage_ctrl
// PURPOSE
//  Sequencer for one R2MDC FFT stage built around the radix-2 butterfly datapath.
//  - Counts butterfly pairs per frame and issues twiddle ROM addresses.
//  - Drives delay-line shift enables and the output commutator select.
//  - Generates the datapath valid pipeline and the end-of-stream flush.
//  - One instance per stage, between the stage's input commutator and the next stage.
// PARAMETERS
//  N      16  FFT points; power of 2, >=4
//  STAGE  0   stage index, 0..log2(N)-1; half-span D = N>>(STAGE+1)
//  AW     3   twiddle address width = log2(N/2)
// PORTS
//  clk       in   1   clock; all logic on the rising edge
//  rst_n     in   1   reset, synchronous, active-low
//  in_valid  in   1   a butterfly input pair (A,B) is presented this cycle
//  in_sof    in   1   qualifies in_valid: pair is k=0 of a new frame
//  flush_req in   1   pulse; drain the delay line after the final frame
//  tw_addr   out  AW  twiddle ROM address (ROM read latency 1)
//  tw_req    out  1   tw_addr is valid (ROM read enable)
//  bf_valid  out  1   butterfly operands and twiddle are aligned at datapath input
//  dl_shift  out  1   shift enable for this stage's output delay line (D/2 deep)
//  sw_sel    out  1   output commutator select: 0 = pass, 1 = cross
//  busy      out  1   high in RUN or FLUSH
//  err       out  1   sticky frame-sync error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - All outputs 0; state IDLE; k=0; valid pipe cleared.
//   - Reset mid-frame or mid-flush abandons that frame; no partial outputs afterwards.
//  FSM:
//   - IDLE: wait for in_valid&in_sof -> RUN with k=0.
//     in_valid without in_sof is ignored (no count, no tw_req).
//   - RUN: each accepted pair advances k.
//     - in_valid=0 is a stall: k holds, tw_req=0, dl_shift=0.
//     - On an accepted pair with k=N/2-1: wrap to k=0 and go to WAIT.
//   - WAIT (busy=0):
//     - in_valid&in_sof -> RUN, back-to-back with no bubble.
//     - Otherwise flush_req -> FLUSH.
//     - in_valid&in_sof and flush_req in the same cycle: the frame wins; flush_req is dropped.
//   - FLUSH: dl_shift=1 and sw_sel keeps sequencing for exactly D/2 cycles, then IDLE.
//     - If D/2==0 (last stage), FLUSH lasts 0 cycles: WAIT -> IDLE directly.
//     - in_valid during FLUSH is ignored.
//   - in_sof with in_valid in RUN while k!=0: treated as a new frame (k restarts at 0), err set.
//  Timing (pair accepted at cycle t with count k):
//   - t+1: tw_addr = (k mod D) << STAGE, truncated to AW bits; tw_req=1.
//   - t+2: bf_valid=1 (2-cycle latency, 1 bubble per stall cycle preserved).
//   - t+2: dl_shift=1 (asserted with bf_valid).
//  Output counter:
//   - m = count of bf_valid cycles in the frame, plus FLUSH cycles.
//   - sw_sel = m[log2(D)-1] when D>=2; sw_sel=0 when D==1.
//   - m resets to 0 at each frame start.
// CONFIGURATION
//  R2MDC_CTRL_ERR_EN:
//   - Defined: err is sticky, set by mid-frame in_sof, cleared only by reset.
//   - Undefined: err is tied 0; resync-on-sof behaviour unchanged.
// TESTING (N=16, STAGE=1, D=4, AW=3)
//  - Reset held 3 cycles, then released: all outputs 0; busy=0.
//  - One frame of 8 contiguous pairs, in_sof on the first:
//    - tw_addr = 0,2,4,6,0,2,4,6 on cycles t+1..t+8.
//    - bf_valid on t+2..t+9.
//    - sw_sel = 0,0,1,1,0,0,1,1.
//  - Same frame with in_valid=0 on the 3rd cycle: k holds; tw_addr sequence unchanged; one-cycle gap in bf_valid.
//  - Two frames back-to-back: second in_sof immediately after k=7; tw_addr continues 0,2,4,6,...; busy stays 1.
//  - flush_req in WAIT:
//    - dl_shift=1 and busy=1 for exactly 2 cycles, then IDLE.
//    - STAGE=3: no flush cycles.
//  - in_sof at k=5: k->0; err=1 (ERR_EN defined) or 0 (undefined).
//  - rst_n=0 mid-flush: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/r2mdc_stage_ctrl.sv
// r2mdc_stage_ctrl: per-stage R2MDC FFT sequencer (twiddle addressing, valid pipe, delay-line/commutator control, flush).
// Define R2MDC_CTRL_ERR_EN to enable the sticky frame-sync error flag on err.
module r2mdc_stage_ctrl #(
  parameter int N     = 16,
  parameter int STAGE = 0,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic          flush_req,
  output logic [AW-1:0] tw_addr,
  output logic          tw_req,
  output logic          bf_valid,
  output logic          dl_shift,
  output logic          sw_sel,
  output logic          busy,
  output logic          err
);

  localparam int D    = N >> (STAGE + 1);
  localparam int HALF = D / 2;
  localparam int MW   = (D >= 2) ? $clog2(D) : 1;
  localparam int FW   = (HALF >= 2) ? $clog2(HALF) : 1;
  localparam logic [AW-1:0] KLAST = AW'(N / 2 - 1);
  localparam logic [AW-1:0] DMASK = AW'(D - 1);
  localparam logic [FW-1:0] FLAST = FW'((HALF > 0) ? HALF - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_FLUSH} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] k_q, kc;
  logic          accept, wrap;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          v1_q, sof1_q, bfv_q, sof2_q;
  logic [AW-1:0] tw_addr_q;
  logic          tw_req_q;
  logic [MW-1:0] m_q, m_d;
  logic          sof_at_dp;

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    kc      = in_sof ? '0 : k_q;
    wrap    = (kc == KLAST);
    fcnt_d  = (state_q == S_FLUSH) ? fcnt_q + 1'b1 : '0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_sof) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          accept = 1'b1;
          if (wrap) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A new frame takes priority over a simultaneous flush request.
        if (in_valid && in_sof) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end else if (flush_req) begin
          state_d = (HALF == 0) ? S_IDLE : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == FLAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sof_at_dp = bfv_q && sof2_q;
    dl_shift  = bfv_q || (state_q == S_FLUSH);
    // The output counter restarts when the frame's first pair reaches the datapath, not when it is accepted.
    if (dl_shift) m_d = sof_at_dp ? MW'(1) : m_q + 1'b1;
    else          m_d = m_q;
    sw_sel    = (D >= 2) && !sof_at_dp && m_q[MW-1];
    // A back-to-back frame start in WAIT counts as busy so busy has no gap between frames.
    busy      = (state_q == S_RUN) || (state_q == S_FLUSH) ||
                ((state_q == S_WAIT) && in_valid && in_sof);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q       <= '0;
      fcnt_q    <= '0;
      v1_q      <= 1'b0;
      sof1_q    <= 1'b0;
      bfv_q     <= 1'b0;
      sof2_q    <= 1'b0;
      tw_req_q  <= 1'b0;
      tw_addr_q <= '0;
      m_q       <= '0;
    end else begin
      if (accept) begin
        k_q       <= wrap ? '0 : kc + 1'b1;
        tw_addr_q <= AW'((kc & DMASK) << STAGE);
      end
      fcnt_q   <= fcnt_d;
      tw_req_q <= accept;
      v1_q     <= accept;
      sof1_q   <= accept && in_sof;
      bfv_q    <= v1_q;
      sof2_q   <= sof1_q;
      m_q      <= m_d;
    end
  end

  assign tw_addr  = tw_addr_q;
  assign tw_req   = tw_req_q;
  assign bf_valid = bfv_q;

`ifdef R2MDC_CTRL_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                                                      err_q <= 1'b0;
    else if ((state_q == S_RUN) && in_valid && in_sof && (k_q != '0)) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_r2mdc_stage_ctrl.sv
// Self-checking bench for r2mdc_stage_ctrl: N=16 at STAGE=1 (D=4) and STAGE=3 (D=1, no flush cycles),
// directed vector table, hand-written corner sequences and a randomized run against a behavioural model.
module tb_r2mdc_stage_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0, flush_req = 1'b0;

  logic [2:0] tw_addr, tw_addr3;
  logic tw_req, bf_valid, dl_shift, sw_sel, busy, err;
  logic tw_req3, bf_valid3, dl_shift3, sw_sel3, busy3, err3;

  int n_cmp = 0;
  int n_err = 0;

`ifdef R2MDC_CTRL_ERR_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  always #5 clk = ~clk;

  r2mdc_stage_ctrl #(.N(16), .STAGE(1), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .flush_req(flush_req),
    .tw_addr(tw_addr), .tw_req(tw_req), .bf_valid(bf_valid), .dl_shift(dl_shift),
    .sw_sel(sw_sel), .busy(busy), .err(err));

  r2mdc_stage_ctrl #(.N(16), .STAGE(3), .AW(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .flush_req(flush_req),
    .tw_addr(tw_addr3), .tw_req(tw_req3), .bf_valid(bf_valid3), .dl_shift(dl_shift3),
    .sw_sel(sw_sel3), .busy(busy3), .err(err3));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step(input logic r, input logic v, input logic s, input logic f);
    @(posedge clk);
    #1;
    rst_n = r; in_valid = v; in_sof = s; flush_req = f;
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    check(name, int'({tw_req, tw_addr, bf_valid, dl_shift, sw_sel, busy, err,
                      tw_req3, tw_addr3, bf_valid3, dl_shift3, sw_sel3, busy3, err3}), 0);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  typedef struct {
    logic v, s, f;
    logic e_req; int e_addr; logic e_bfv, e_dl, e_sw, e_busy;
    logic e_busy3, e_dl3;
  } vec_t;

  // Behavioural reference for the randomized run, index 0 = STAGE 1, index 1 = STAGE 3.
  localparam int L = 600;
  logic st_v[L], st_s[L], st_f[L];
  logic e_req[2][L+3], e_bfv[2][L+3], e_bsof[2][L+3], e_dl[2][L+3];
  logic e_sw[2][L+3], e_busy[2][L+3], e_err[2][L+3];
  int   e_addr[2][L+3];

  task automatic build_model(input int si, input int stg);
    int d, mode, k, fl, m, kk;
    bit errs, acc, dl;
    d = 16 >> (stg + 1);
    mode = 0; k = 0; fl = 0; m = 0; errs = 0;   // mode: 0 idle, 1 run, 2 wait, 3 flush
    for (int t = 0; t < L + 3; t++) begin
      e_req[si][t] = 0; e_bfv[si][t] = 0; e_bsof[si][t] = 0; e_addr[si][t] = 0;
    end
    for (int t = 0; t < L; t++) begin
      e_err[si][t]  = errs;
      e_busy[si][t] = (mode == 1) || (mode == 3) || (mode == 2 && st_v[t] && st_s[t]);
      dl = e_bfv[si][t] || (mode == 3);
      e_dl[si][t] = dl;
      e_sw[si][t] = 0;
      if (dl) begin
        if (e_bsof[si][t]) m = 0;
        e_sw[si][t] = (d >= 2) ? (((m / (d / 2)) % 2) == 1) : 1'b0;
        m++;
      end
      acc = ((mode == 0 || mode == 2) && st_v[t] && st_s[t]) || (mode == 1 && st_v[t]);
      if (acc) begin
        kk = st_s[t] ? 0 : k;
`ifdef R2MDC_CTRL_ERR_EN
        if (mode == 1 && st_s[t] && k != 0) errs = 1;
`endif
        e_req[si][t+1]  = 1;
        e_addr[si][t+1] = ((kk % d) << stg) % 8;
        e_bfv[si][t+2]  = 1;
        e_bsof[si][t+2] = st_s[t];
        k    = (kk == 7) ? 0 : kk + 1;
        mode = (kk == 7) ? 2 : 1;
      end else if (mode == 2 && st_f[t]) begin
        if (d / 2 == 0) mode = 0;
        else begin mode = 3; fl = d / 2; end
      end else if (mode == 3) begin
        fl--;
        if (fl == 0) mode = 0;
      end
    end
  endtask

  initial begin
    vec_t tbl[15];
    int q_tw[$], q_sw[$];
    logic [12:0] vpat, bmask, bexp;
    int bcnt;

    //             v  s  f  req addr bfv dl sw busy busy3 dl3
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0};
    tbl[3]  = '{1, 0, 0, 1, 2, 1, 1, 0, 1, 1, 1};
    tbl[4]  = '{1, 0, 0, 1, 4, 1, 1, 0, 1, 1, 1};
    tbl[5]  = '{1, 0, 0, 1, 6, 1, 1, 1, 1, 1, 1};
    tbl[6]  = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
    tbl[7]  = '{1, 0, 0, 1, 2, 1, 1, 0, 1, 1, 1};
    tbl[8]  = '{1, 0, 0, 1, 4, 1, 1, 0, 1, 1, 1};
    tbl[9]  = '{0, 0, 0, 1, 6, 1, 1, 1, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset held for 3 edges with a frame start presented, then released.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0);
      check_zero($sformatf("reset_hold%0d", i));
    end
    step(1, 0, 0, 0);
    check_zero("reset_release");

    // One frame, flush with D/2=2 cycles (STAGE 3 flushes for 0 cycles).
    for (int i = 0; i < 15; i++) begin
      step(1, tbl[i].v, tbl[i].s, tbl[i].f);
      check($sformatf("tbl%0d_tw_req", i), tw_req, tbl[i].e_req);
      if (tbl[i].e_req) check($sformatf("tbl%0d_tw_addr", i), tw_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_bf_valid", i), bf_valid, tbl[i].e_bfv);
      check($sformatf("tbl%0d_dl_shift", i), dl_shift, tbl[i].e_dl);
      if (tbl[i].e_dl) check($sformatf("tbl%0d_sw_sel", i), sw_sel, tbl[i].e_sw);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_busy_s3", i), busy3, tbl[i].e_busy3);
      check($sformatf("tbl%0d_dl_shift_s3", i), dl_shift3, tbl[i].e_dl3);
    end

    // Frame with a stall on its 3rd cycle.
    vpat = 13'h1FB;
    bexp = vpat << 2;
    bmask = '0;
    q_tw.delete(); q_sw.delete();
    for (int c = 0; c < 13; c++) begin
      step(1, vpat[c], c == 0, 0);
      if (tw_req) q_tw.push_back(int'(tw_addr));
      bmask[c] = bf_valid;
      if (bf_valid) q_sw.push_back(int'(sw_sel));
    end
    check("stall_bf_valid_pattern", int'(bmask), int'(bexp));
    check("stall_tw_count", q_tw.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("stall_tw%0d", i), qget(q_tw, i), (i % 4) * 2);
      check($sformatf("stall_sw%0d", i), qget(q_sw, i), (i / 2) % 2);
    end

    // Two frames back-to-back.
    q_tw.delete(); q_sw.delete();
    bcnt = 0;
    for (int c = 0; c < 18; c++) begin
      step(1, c < 16, (c == 0) || (c == 8), 0);
      if (c < 16 && busy) bcnt++;
      if (tw_req) q_tw.push_back(int'(tw_addr));
      if (bf_valid) q_sw.push_back(int'(sw_sel));
    end
    check("b2b_busy_cycles", bcnt, 16);
    check("b2b_tw_count", q_tw.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b2b_tw%0d", i), qget(q_tw, i), (i % 4) * 2);
      check($sformatf("b2b_sw%0d", i), qget(q_sw, i), (i / 2) % 2);
    end
    check("b2b_err", err, 0);

    // Mid-frame in_sof at k=5 resynchronises the frame.
    q_tw.delete(); q_sw.delete();
    for (int c = 0; c < 15; c++) begin
      step(1, c < 13, (c == 0) || (c == 5), 0);
      if (c == 5) check("resync_err_before", err, 0);
      if (c == 6) check("resync_err_after", err, ERR_EXP);
      if (tw_req) q_tw.push_back(int'(tw_addr));
      if (bf_valid) q_sw.push_back(int'(sw_sel));
    end
    check("resync_tw_count", q_tw.size(), 13);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("resync_tw%0d", i), qget(q_tw, i), ((i < 5 ? i : i - 5) % 4) * 2);
      check($sformatf("resync_sw%0d", i), qget(q_sw, i), ((i < 5 ? i : i - 5) / 2) % 2);
    end
    check("resync_err_sticky", err, ERR_EXP);

    // Reset in the middle of a flush.
    step(1, 0, 0, 1);
    check("midflush_wait_busy", busy, 0);
    step(0, 0, 0, 0);
    check("midflush_busy", busy, 1);
    check("midflush_dl_shift", dl_shift, 1);
    step(1, 0, 0, 0);
    check_zero("midflush_reset");

    // Randomized run against the behavioural model.
    for (int t = 0; t < L; t++) begin
      st_v[t] = ($urandom_range(3) != 0);
      st_s[t] = ($urandom_range(11) == 0);
      st_f[t] = ($urandom_range(9) == 0);
    end
    build_model(0, 1);
    build_model(1, 3);
    for (int t = 0; t < L; t++) begin
      step(1, st_v[t], st_s[t], st_f[t]);
      for (int si = 0; si < 2; si++) begin
        check($sformatf("rnd%0d_s%0d_tw_req", t, si), si ? tw_req3 : tw_req, e_req[si][t]);
        if (e_req[si][t])
          check($sformatf("rnd%0d_s%0d_tw_addr", t, si), si ? tw_addr3 : tw_addr, e_addr[si][t]);
        check($sformatf("rnd%0d_s%0d_bf_valid", t, si), si ? bf_valid3 : bf_valid, e_bfv[si][t]);
        check($sformatf("rnd%0d_s%0d_dl_shift", t, si), si ? dl_shift3 : dl_shift, e_dl[si][t]);
        if (e_dl[si][t])
          check($sformatf("rnd%0d_s%0d_sw_sel", t, si), si ? sw_sel3 : sw_sel, e_sw[si][t]);
        check($sformatf("rnd%0d_s%0d_busy", t, si), si ? busy3 : busy, e_busy[si][t]);
        check($sformatf("rnd%0d_s%0d_err", t, si), si ? err3 : err, e_err[si][t]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
